mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
Multicycle MIPS main control unit. It decodes the 6-bit opcode and sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath enables and muxes, and provides the 2-bit ALUctr that the downstream ALUop decoder combines with func to form ALU_op. Memory accesses use a simple ready handshake so that multi-cycle memories stall the sequence.

Parameters:
ST_W, 4, width of state register and state_o debug port
OP_W, 6, opcode width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
op  input  6  instruction opcode (IR[31:26]), valid from DECODE onward
zero  input  1  ALU zero flag, sampled in BRANCH
mem_ready  input  1  memory completes the current access this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load qualified by zero (beq)
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  instruction register load
MemtoReg  output  1  writeback select: 0=ALUOut, 1=MDR
RegDst  output  1  destination select: 0=rt, 1=rd
RegWrite  output  1  register file write
ALUSrcA  output  1  0=PC, 1=rs
ALUSrcB  output  2  00=rt, 01=4, 10=signext imm, 11=signext imm<<2
ALUctr  output  2  00=add, 01=sub, 10=R-type (use func), 11=or
PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target
illegal_op  output  1  one-cycle pulse on unrecognised opcode
state_o  output  4  current state encoding (debug)

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- State encoding:
  - INIT=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6
  - EXEC=7, RWB=8, BRANCH=9, JUMP=10, IEXEC=11, IWB=12
- Reset:
  - rst_n low forces INIT asynchronously, at any time, including mid-instruction.
  - In INIT every output is 0, state_o=0.
  - INIT -> FETCH on the first clock edge after rst_n is high.
- Moore decode of outputs from the state register, except the handshake qualifiers noted below. Every signal not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUctr=00, PCSource=00.
  - IRWrite and PCWrite = mem_ready (Mealy qualified).
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUctr=00. Next state by op:
  - 100011/101011 -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000/001101 -> IEXEC
  - any other op -> FETCH, with illegal_op=1 for this single cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUctr=00. Next state is MEMRD for lw, MEMWR for sw.
  - op is held stable by the IR, so it is re-examined here.
- MEMRD: MemRead=1, IorD=1. Stay until mem_ready=1, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next state FETCH.
- MEMWR: MemWrite=1, IorD=1. Stay until mem_ready=1, then FETCH.
  - MemWrite remains asserted for every wait cycle.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUctr=10. Next state RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUctr=01, PCWriteCond=1, PCSource=01. Next state FETCH.
  - zero is consumed by the datapath AND-gate; the FSM does not branch on it.
- JUMP: PCWrite=1, PCSource=10. Next state FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10. ALUctr=00 for addi, 11 for ori. Next state IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0. Next state FETCH.
- Latencies in cycles, excluding memory waits: lw 5, sw 4, R-type 4, addi/ori 4, beq 3, j 3.
- Safety and exclusivity:
  - Unused state encodings 13-15 -> INIT on the next clock.
  - MemRead and MemWrite are never both 1.
  - RegWrite and MemWrite are never both 1.

Test Plan:
1. Reset and start-up:
   - Stimulus: hold rst_n=0 for 3 cycles, mem_ready=1, then release.
   - Required: all outputs 0 with state_o=0 during reset. After release: INIT then FETCH (state_o=1, MemRead=1, PCWrite=1, IRWrite=1), then DECODE.
2. R-type with op=000000, mem_ready=1:
   - Required: state_o sequence 1,2,7,8,1. ALUctr=10 in EXEC. RegWrite=1 and RegDst=1 only in RWB.
3. lw with op=100011 and mem_ready low for 2 cycles in MEMRD:
   - Required: state_o sequence 1,2,3,4,4,4,5,1. IorD=1 and MemRead=1 during all three MEMRD cycles. MemtoReg=1 and RegWrite=1 in MEMWB.
4. FETCH stall: mem_ready=0 for 3 cycles in FETCH.
   - Required: state_o stays 1. PCWrite=0 and IRWrite=0 until the mem_ready=1 cycle, where both pulse for exactly 1 cycle.
5. beq (000100), j (000010), ori (001101):
   - beq: BRANCH with ALUctr=01, PCWriteCond=1, PCSource=01.
   - j: JUMP with PCWrite=1, PCSource=10.
   - ori: IEXEC with ALUctr=11, ALUSrcB=10, then IWB with RegWrite=1, RegDst=0.
6. Illegal opcode and reset mid-operation:
   - op=111111 in DECODE: illegal_op=1 for one cycle, next state_o=1.
   - Separately, pull rst_n=0 asynchronously mid-MEMWR: MemWrite drops to 0 immediately and state_o=0.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control unit: sequences fetch/decode/execute/memory/writeback
// and drives the datapath enables, mux selects and the 2-bit ALUctr.
module mc_control_fsm #(
    parameter int ST_W = 4,
    parameter int OP_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] op,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            MemtoReg,
    output logic            RegDst,
    output logic            RegWrite,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ALUctr,
    output logic [1:0]      PCSource,
    output logic            illegal_op,
    output logic [ST_W-1:0] state_o
);

    typedef enum logic [ST_W-1:0] {
        S_INIT   = ST_W'(0),
        S_FETCH  = ST_W'(1),
        S_DECODE = ST_W'(2),
        S_MEMADR = ST_W'(3),
        S_MEMRD  = ST_W'(4),
        S_MEMWB  = ST_W'(5),
        S_MEMWR  = ST_W'(6),
        S_EXEC   = ST_W'(7),
        S_RWB    = ST_W'(8),
        S_BRANCH = ST_W'(9),
        S_JUMP   = ST_W'(10),
        S_IEXEC  = ST_W'(11),
        S_IWB    = ST_W'(12)
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;

    state_e state_q, state_d;

    // zero feeds the datapath AND-gate with PCWriteCond; the FSM never branches on it.
    logic unused_zero;
    assign unused_zero = zero;

    assign state_o = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake: in FETCH/MEMRD/MEMWR the request is held every cycle and the
    // access completes on the cycle mem_ready=1; only then does the state advance.
    always_comb begin
        state_d     = S_INIT;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUctr      = 2'b00;
        PCSource    = 2'b00;
        illegal_op  = 1'b0;
        case (state_q)
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (op)
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_RTYPE:         state_d = S_EXEC;
                    OP_BEQ:           state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    OP_ADDI, OP_ORI:  state_d = S_IEXEC;
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (op == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (op == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                state_d  = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUctr  = 2'b10;
                state_d = S_RWB;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUctr      = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = S_FETCH;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUctr  = (op == OP_ORI) ? 2'b11 : 2'b00;
                state_d = S_IWB;
            end
            S_IWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: planned per-instruction state traces feed an
// expected-output queue that a single compare process checks every cycle.
module tb_mc_control_fsm;

    localparam int W = 21;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, ALUctr, PCSource;
    logic [3:0] state_o;

    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUctr(ALUctr),
        .PCSource(PCSource), .illegal_op(illegal_op), .state_o(state_o)
    );

    // clock and reset
    always #10 clk = ~clk;

    logic [W-1:0] dut_vec;
    assign dut_vec = {state_o, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                      MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUctr, PCSource,
                      illegal_op};

    // Output table per control step, written straight from the state descriptions.
    function automatic logic [W-1:0] model(input int st, input logic [5:0] o, input logic mr);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill;
        logic [1:0] asb, actr, pcs;
        logic [3:0] s4;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill} = '0;
        asb  = 2'd0;
        actr = 2'd0;
        pcs  = 2'd0;
        s4   = 4'(st);
        case (st)
            1:  begin mrd = 1; asb = 2'd1; pcw = mr; irw = mr; end
            2:  begin
                    asb = 2'd3;
                    ill = !(o == OP_R || o == OP_LW || o == OP_SW || o == OP_BEQ ||
                            o == OP_J || o == OP_ADDI || o == OP_ORI);
                end
            3:  begin asa = 1; asb = 2'd2; end
            4:  begin mrd = 1; iord = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mwr = 1; iord = 1; end
            7:  begin asa = 1; actr = 2'd2; end
            8:  begin rw = 1; rdst = 1; end
            9:  begin asa = 1; actr = 2'd1; pcwc = 1; pcs = 2'd1; end
            10: begin pcw = 1; pcs = 2'd2; end
            11: begin asa = 1; asb = 2'd2; actr = (o == OP_ORI) ? 2'd3 : 2'd0; end
            12: begin rw = 1; end
            default: ;
        endcase
        return {s4, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, actr, pcs, ill};
    endfunction

    // driver: one clock cycle of stimulus plus the expected outputs for it
    task automatic cyc(input int st, input logic [5:0] o, input logic mr, input logic rst);
        @(negedge clk);
        rst_n     = rst;
        op        = o;
        mem_ready = mr;
        zero      = 1'($urandom_range(0, 1));
        exp_q.push_back(model(rst ? st : 0, o, mr));
    endtask

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One whole instruction from FETCH, with fw fetch waits and mw data-memory waits.
    task automatic instr(input logic [5:0] o, input int fw, input int mw);
        logic dc;
        for (int i = 0; i < fw; i++) cyc(1, o, 1'b0, 1'b1);
        cyc(1, o, 1'b1, 1'b1);
        dc = 1'($urandom_range(0, 1));
        cyc(2, o, dc, 1'b1);
        case (o)
            OP_LW: begin
                cyc(3, o, 1'($urandom_range(0, 1)), 1'b1);
                for (int i = 0; i < mw; i++) cyc(4, o, 1'b0, 1'b1);
                cyc(4, o, 1'b1, 1'b1);
                cyc(5, o, 1'($urandom_range(0, 1)), 1'b1);
            end
            OP_SW: begin
                cyc(3, o, 1'($urandom_range(0, 1)), 1'b1);
                for (int i = 0; i < mw; i++) cyc(6, o, 1'b0, 1'b1);
                cyc(6, o, 1'b1, 1'b1);
            end
            OP_R: begin
                cyc(7, o, 1'($urandom_range(0, 1)), 1'b1);
                cyc(8, o, 1'($urandom_range(0, 1)), 1'b1);
            end
            OP_BEQ: cyc(9, o, 1'($urandom_range(0, 1)), 1'b1);
            OP_J:   cyc(10, o, 1'($urandom_range(0, 1)), 1'b1);
            OP_ADDI, OP_ORI: begin
                cyc(11, o, 1'($urandom_range(0, 1)), 1'b1);
                cyc(12, o, 1'($urandom_range(0, 1)), 1'b1);
            end
            default: ;
        endcase
    endtask

    // scoreboard: compare every driven cycle, mid-low phase
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (dut_vec !== e) begin
                    n_err++;
                    $display("FAIL cycle_vec @%0t: got state=%0d bits=%05h, expected state=%0d bits=%05h",
                             $time, dut_vec[W-1:W-4], dut_vec[W-5:0], e[W-1:W-4], e[W-5:0]);
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        op        = 6'd0;
        zero      = 1'b0;
        mem_ready = 1'b1;

        // 1: reset held 3 cycles, release, then walk the first instruction
        for (int i = 0; i < 3; i++) cyc(0, OP_R, 1'b1, 1'b0);
        #3 check_lit("reset_state", 32'(state_o), 32'd0);
        cyc(0, OP_R, 1'b1, 1'b1);
        cyc(1, OP_R, 1'b1, 1'b1);
        #3 check_lit("fetch_state", 32'(state_o), 32'd1);
        check_lit("fetch_rd_pcw_irw", 32'({MemRead, PCWrite, IRWrite}), 32'h7);
        cyc(2, OP_R, 1'b1, 1'b1);
        #3 check_lit("decode_state", 32'(state_o), 32'd2);
        cyc(7, OP_R, 1'b1, 1'b1);
        #3 check_lit("exec_aluctr", 32'(ALUctr), 32'h2);
        cyc(8, OP_R, 1'b1, 1'b1);
        #3 check_lit("rwb_rw_rdst", 32'({RegWrite, RegDst}), 32'h3);

        // 2: R-type
        instr(OP_R, 0, 0);
        // 3: lw with two memory wait cycles
        instr(OP_LW, 0, 2);
        // 4: fetch stall of three cycles
        instr(OP_R, 3, 0);
        // 5: branch, jump, immediates, store
        instr(OP_BEQ, 0, 0);
        instr(OP_J, 1, 0);
        instr(OP_ORI, 0, 0);
        instr(OP_ADDI, 2, 0);
        instr(OP_SW, 0, 3);
        instr(OP_LW, 1, 0);
        instr(OP_SW, 0, 0);
        // 6: illegal opcode returns straight to FETCH
        instr(OP_BAD, 0, 0);
        instr(6'b010101, 1, 0);
        instr(OP_BEQ, 0, 0);

        // 6: asynchronous reset while a store waits for memory
        cyc(1, OP_SW, 1'b1, 1'b1);
        cyc(2, OP_SW, 1'b1, 1'b1);
        cyc(3, OP_SW, 1'b1, 1'b1);
        cyc(6, OP_SW, 1'b0, 1'b1);
        cyc(6, OP_SW, 1'b0, 1'b1);
        #3 check_lit("memwr_before_rst", 32'(MemWrite), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_lit("async_rst_memwrite", 32'(MemWrite), 32'd0);
        check_lit("async_rst_state", 32'(state_o), 32'd0);
        cyc(0, OP_SW, 1'b0, 1'b0);
        cyc(0, OP_SW, 1'b1, 1'b1);
        instr(OP_R, 0, 0);
        instr(OP_LW, 0, 1);

        @(negedge clk);
        #4;
        check_lit("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
